// File: rtl/imem_arbiter.sv
// imem_arbiter
//
// Shares the single read port of the instruction memory between the core
// fetch path (F) and the debug/program-inspection port (D). A round-robin
// pointer picks at most one request per cycle. A LAT-deep positional tracker
// routes each read's data back to its owner exactly LAT cycles later. A fetch
// flush drops every in-flight fetch read after a PC redirect.
//
// Parameters
//   ADDR_W  byte address width presented to the memory
//   DATA_W  instruction word width
//   LAT     memory read latency in cycles (1..4)
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_f_req, i_f_addr, i_f_flush    fetch request, address, in-flight discard
//   o_f_gnt, o_f_rvalid, o_f_rdata  fetch accept, read data valid, read data
//   i_d_req, i_d_addr               debug request, address
//   o_d_gnt, o_d_rvalid, o_d_rdata  debug accept, read data valid, read data
//   o_mem_en, o_mem_addr            memory read strobe and address
//   i_mem_rdata                     memory data, valid LAT cycles after o_mem_en
module imem_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  input  logic              i_f_flush,
  output logic              o_f_gnt,
  output logic              o_f_rvalid,
  output logic [DATA_W-1:0] o_f_rdata,
  input  logic              i_d_req,
  input  logic [ADDR_W-1:0] i_d_addr,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic {
    OwnF = 1'b0,
    OwnD = 1'b1
  } owner_e;

  // Round-robin pointer: owner of the most recent accepted read.
  owner_e last_q, last_d;

  logic f_gnt, d_gnt, accept;

  // Tracker stages; index 0 is the newest read, LAT-1 is at the output.
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] own_q, own_d;

  logic tail_vld, tail_own;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!i_rst) begin
      unique case ({i_f_req, i_d_req})
        2'b10: f_gnt = 1'b1;
        2'b01: d_gnt = 1'b1;
        2'b11: begin
          // Tie: the side that did not win last time goes now.
          if (last_q == OwnD) begin
            f_gnt = 1'b1;
          end else begin
            d_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign accept = f_gnt | d_gnt;

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = d_gnt ? OwnD : OwnF;
    end
  end

  always_comb begin
    o_mem_addr = '0;
    if (d_gnt) begin
      o_mem_addr = i_d_addr;
    end else if (f_gnt) begin
      o_mem_addr = i_f_addr;
    end
  end

  assign o_f_gnt  = f_gnt;
  assign o_d_gnt  = d_gnt;
  assign o_mem_en = accept;

  // ---------------------------------------------------------------------
  // Response tracker
  // ---------------------------------------------------------------------
  always_comb begin
    vld_d = '0;
    own_d = '0;
    // A read accepted in the flush cycle belongs to the new path, so stage 0
    // is loaded unconditionally.
    vld_d[0] = accept;
    own_d[0] = d_gnt;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1] & ~(i_f_flush & ~own_q[i-1]);
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= OwnD;
      vld_q  <= '0;
      own_q  <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
    end
  end

  assign tail_vld = vld_q[LAT-1];
  assign tail_own = own_q[LAT-1];

  // The entry at the output is squashed combinationally when a flush arrives
  // in the same cycle; the edge then clears it along with the rest.
  assign o_f_rvalid = tail_vld & ~tail_own & ~i_f_flush & ~i_rst;
  assign o_d_rvalid = tail_vld &  tail_own & ~i_rst;

  assign o_f_rdata = o_f_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata = o_d_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: four instances (LAT = 1..4) share one stimulus
// stream; a scheduling model predicts grants and return cycles per latency.
module tb_imem_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, f_flush, d_req;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] mem_rdata;

  logic [3:0]    f_gnt, d_gnt, mem_en, f_rv, d_rv;
  logic [AW-1:0] mem_addr [4];
  logic [DW-1:0] f_rd [4];
  logic [DW-1:0] d_rd [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    imem_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .LAT   (g + 1)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_f_req    (f_req),
      .i_f_addr   (f_addr),
      .i_f_flush  (f_flush),
      .o_f_gnt    (f_gnt[g]),
      .o_f_rvalid (f_rv[g]),
      .o_f_rdata  (f_rd[g]),
      .i_d_req    (d_req),
      .i_d_addr   (d_addr),
      .o_d_gnt    (d_gnt[g]),
      .o_d_rvalid (d_rv[g]),
      .o_d_rdata  (d_rd[g]),
      .o_mem_en   (mem_en[g]),
      .o_mem_addr (mem_addr[g]),
      .i_mem_rdata(mem_rdata)
    );
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: reads are scheduled into a ring of return slots by due cycle.
  int unsigned cyc = 0;
  bit          m_last = 1'b1;   // 1 = D won last
  bit          sv [4][8];
  bit          so [4][8];

  task automatic model_check();
    bit                efg, edg, acc, efr, edr;
    logic [AW-1:0]     ea;
    int unsigned       slot;
    efg  = !rst && f_req && (!d_req || m_last);
    edg  = !rst && d_req && (!f_req || !m_last);
    acc  = efg || edg;
    ea   = edg ? d_addr : (efg ? f_addr : '0);
    slot = cyc % 8;
    for (int l = 0; l < 4; l++) begin
      if (rst) begin
        for (int s = 0; s < 8; s++) sv[l][s] = 1'b0;
      end
      efr = sv[l][slot] && !so[l][slot] && !f_flush;
      edr = sv[l][slot] && so[l][slot];
      chk($sformatf("f_gnt L%0d", l + 1), 32'(f_gnt[l]), 32'(efg));
      chk($sformatf("d_gnt L%0d", l + 1), 32'(d_gnt[l]), 32'(edg));
      chk($sformatf("mem_en L%0d", l + 1), 32'(mem_en[l]), 32'(acc));
      chk($sformatf("mem_addr L%0d", l + 1), 32'(mem_addr[l]), 32'(ea));
      chk($sformatf("f_rvalid L%0d", l + 1), 32'(f_rv[l]), 32'(efr));
      chk($sformatf("d_rvalid L%0d", l + 1), 32'(d_rv[l]), 32'(edr));
      chk($sformatf("f_rdata L%0d", l + 1), f_rd[l], efr ? mem_rdata : 32'h0);
      chk($sformatf("d_rdata L%0d", l + 1), d_rd[l], edr ? mem_rdata : 32'h0);
      sv[l][slot] = 1'b0;
      if (f_flush) begin
        for (int s = 0; s < 8; s++) if (!so[l][s]) sv[l][s] = 1'b0;
      end
      if (acc) begin
        sv[l][(cyc + l + 1) % 8] = 1'b1;
        so[l][(cyc + l + 1) % 8] = edg;
      end
    end
    if (rst) m_last = 1'b1;
    else if (acc) m_last = edg;
    cyc++;
  endtask

  // One cycle: advance to the edge, drive, settle mid-cycle, check.
  task automatic step(input bit fr, input logic [AW-1:0] fa, input bit dr,
                      input logic [AW-1:0] da, input bit fl, input bit rs,
                      input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
    f_flush = fl; rst = rs; mem_rdata = rd;
    #3;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, $urandom);
  endtask

  typedef struct {
    bit            fr;
    logic [AW-1:0] fa;
    bit            dr;
    logic [AW-1:0] da;
    bit            fl;
    bit            rs;
    bit            e_fg;
    bit            e_dg;
    bit            e_frv;   // LAT=1 instance
    bit            e_drv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    rst = 1'b1; f_req = 0; d_req = 0; f_addr = '0; d_addr = '0;
    f_flush = 0; mem_rdata = '0;

    //        fr  fa       dr  da       fl rs fg dg frv drv
    tbl[0]  = '{1, 13'h004, 0, 13'h000, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 13'h008, 1, 13'h100, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 13'h008, 1, 13'h104, 0, 0, 1, 0, 0, 1};
    tbl[3]  = '{1, 13'h00c, 1, 13'h104, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 13'h000, 0, 13'h000, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 13'h000, 1, 13'h1ff, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 13'h000, 1, 13'h1fc, 0, 0, 0, 1, 0, 1};
    tbl[7]  = '{1, 13'h1ffc, 1, 13'h020, 0, 0, 1, 0, 0, 1};
    tbl[8]  = '{1, 13'h010, 0, 13'h000, 1, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 13'h000, 0, 13'h000, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{1, 13'h014, 1, 13'h030, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{1, 13'h014, 1, 13'h030, 0, 0, 1, 0, 0, 0};

    // Reset state
    step(0, '0, 0, '0, 0, 1, 32'hdeadbeef);
    step(1, 13'h123, 1, 13'h456, 0, 1, 32'hdeadbeef);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].da, tbl[i].fl, tbl[i].rs, $urandom);
      chk($sformatf("tbl%0d f_gnt", i), 32'(f_gnt[0]), 32'(tbl[i].e_fg));
      chk($sformatf("tbl%0d d_gnt", i), 32'(d_gnt[0]), 32'(tbl[i].e_dg));
      chk($sformatf("tbl%0d f_rvalid", i), 32'(f_rv[0]), 32'(tbl[i].e_frv));
      chk($sformatf("tbl%0d d_rvalid", i), 32'(d_rv[0]), 32'(tbl[i].e_drv));
    end
    idle(6);

    // Single fetch, LAT=2
    step(1, 13'h004, 0, '0, 0, 0, 32'h1);
    chk("single gnt", 32'(f_gnt[1]), 32'h1);
    chk("single addr", 32'(mem_addr[1]), 32'h004);
    step(0, '0, 0, '0, 0, 0, 32'h2);
    chk("single early rv", 32'(f_rv[1]), 32'h0);
    step(0, '0, 0, '0, 0, 0, 32'h00500093);
    chk("single rv", 32'(f_rv[1]), 32'h1);
    chk("single rdata", f_rd[1], 32'h00500093);
    step(0, '0, 0, '0, 0, 0, 32'h3);
    chk("single late rv", 32'(f_rv[1]), 32'h0);
    idle(6);

    // Flush, LAT=3: only the read accepted with the flush survives
    step(1, 13'h040, 0, '0, 0, 0, $urandom);
    step(1, 13'h044, 0, '0, 0, 0, $urandom);
    step(1, 13'h080, 0, '0, 1, 0, $urandom);
    step(0, '0, 0, '0, 0, 0, $urandom);
    chk("flush c4 rv", 32'(f_rv[2]), 32'h0);
    step(0, '0, 0, '0, 0, 0, $urandom);
    chk("flush c5 rv", 32'(f_rv[2]), 32'h0);
    step(0, '0, 0, '0, 0, 0, 32'hcafe0001);
    chk("flush c6 rv", 32'(f_rv[2]), 32'h1);
    chk("flush c6 rdata", f_rd[2], 32'hcafe0001);
    idle(6);

    // Flush with mixed owners, LAT=2
    step(0, '0, 1, 13'h200, 0, 0, $urandom);
    step(1, 13'h050, 0, '0, 0, 0, $urandom);
    step(0, '0, 0, '0, 1, 0, $urandom);
    chk("mixed d_rv", 32'(d_rv[1]), 32'h1);
    step(0, '0, 0, '0, 0, 0, $urandom);
    chk("mixed f_rv", 32'(f_rv[1]), 32'h0);
    idle(6);

    // Reset mid-flight, LAT=4
    step(1, 13'h060, 0, '0, 0, 0, $urandom);
    step(0, '0, 0, '0, 0, 1, $urandom);
    for (int c = 3; c <= 6; c++) begin
      step(0, '0, 0, '0, 0, 0, $urandom);
      chk($sformatf("rst c%0d f_rv", c), 32'(f_rv[3]), 32'h0);
    end
    step(1, 13'h070, 1, 13'h300, 0, 0, $urandom);
    chk("rst tie f_gnt", 32'(f_gnt[3]), 32'h1);
    idle(6);

    // Idle
    for (int c = 0; c < 10; c++) begin
      step(0, '0, 0, '0, 0, 0, $urandom);
      chk("idle mem_en", 32'(mem_en), 32'h0);
      chk("idle rdata", f_rd[0] | d_rd[0] | f_rd[3] | d_rd[3], 32'h0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(bit'($urandom_range(0, 3) != 0), AW'($urandom), bit'($urandom_range(0, 2) != 0),
           AW'($urandom), bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 99) == 0),
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
